multi_device_cu: RTL and testbench
==================================

MULTI_DEVICE_CU -- requirements
Module: multi_device_cu

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 8'h10, meaning first device address served.
REQ-002 SHALL have parameter NUM_DEVICES, default 4, range 1..16, meaning devices served at BASE_ADDRESS..BASE_ADDRESS+NUM_DEVICES-1.
REQ-003 SHALL have parameter LIMIT_WIDTH, default 16, meaning width of each per-device byte limit.
REQ-004 SHALL have parameter ENABLE_SHORT_BUSY, default 0, meaning busy is reported by the short-busy sequence when 1.
REQ-005 SHALL have the ports below; reset is asynchronous and active-low.
clk  in  1  single clock
reset_n  in  1  asynchronous active-low reset
b_bus_out, b_bus_out_parity  in  8,1  channel-side bus out, odd parity
b_operational_out, b_hold_out, b_select_out, b_address_out, b_command_out, b_service_out, b_suppress_out  in  1 each  channel-side out tags
b_bus_in, b_bus_in_parity  out  8,1  channel-side bus in, odd parity
b_operational_in, b_request_in, b_select_in, b_address_in, b_status_in, b_service_in  out  1 each  channel-side in tags
a_* mirror set  opposite directions  same widths  downstream interface toward the next CU
mock_busy  in  NUM_DEVICES  per-device busy
mock_limit  in  NUM_DEVICES*LIMIT_WIDTH  per-device byte limit, device i at bits [i*LIMIT_WIDTH +: LIMIT_WIDTH]
last_write_data  out  8  last byte accepted on a write
xfer_count  out  LIMIT_WIDTH  bytes moved in the current or last operation

Function
REQ-006 SHALL forward all b_ out-tags and bus out to a_ unchanged, except select_out.
REQ-007 SHALL drive b_ in-lines with a_ in-lines while not connected, and with its own lines while connected.
REQ-008 SHALL use states IDLE, PROPAGATE, ADDR_IN, CMD_WAIT, INIT_STATUS, DATA, END_STATUS, DISCONNECT, each in-tag transition registered one cycle after the sampled channel edge.
REQ-009 In IDLE, on select_out with address_out and bus_out in range, it SHALL raise operational_in and go to ADDR_IN; out of range, it SHALL pass select_out to a_select_out (PROPAGATE) until select_out falls.
REQ-010 ADDR_IN SHALL drive the address on bus_in with address_in until address_out falls.
REQ-011 CMD_WAIT SHALL latch the command when command_out rises and drop address_in; then INIT_STATUS.
REQ-012 Initial status SHALL be: busy device 8'h10; READ 8'h02 or WRITE 8'h01 8'h00; NOP 8'h03 8'h0C; SENSE 8'h04 8'h00; any other command 8'h0E with command-reject sense bit set.
REQ-013 Status SHALL be held on status_in until service_out or command_out (both accept; stacking unsupported); nonzero initial status SHALL lead to DISCONNECT.
REQ-014 DATA SHALL raise service_in per byte; READ byte k = k[7:0]; WRITE latches bus_out into last_write_data on service_out.
REQ-015 xfer_count SHALL increment per service_out-accepted byte and clear at each new selection.
REQ-016 DATA SHALL end when xfer_count equals the device limit, including limit 0, or when command_out (stop) answers service_in; ending status 8'h0C.
REQ-017 SENSE SHALL transfer one byte {command_reject, 1'b0, bus_out_check, 5'b0}, then clear that device's sense.
REQ-018 A bus_out parity error on command or write data SHALL set bus_out_check and make the ending status 8'h0E.
REQ-019 With ENABLE_SHORT_BUSY=1 and the device busy, selection SHALL present status 8'h50 in place of address_in, then disconnect after acceptance.
REQ-020 DISCONNECT SHALL drop operational_in once service_out/command_out falls, then return to IDLE.
REQ-021 operational_out low in any state SHALL drop all own in-tags next cycle and return to IDLE; sense is kept.
REQ-022 b_bus_in_parity SHALL always be the odd parity of b_bus_in.

Reset
REQ-023 reset_n low SHALL immediately clear state to IDLE, all own in-tags, last_write_data, xfer_count and all sense bits.
REQ-024 reset_n low mid-operation SHALL leave the b_ in-lines equal to the a_ in-lines.

Structure
REQ-025 Command codes, status bits and sense bit positions SHALL live in a shared bus-and-tag package.
REQ-026 A sub-module cu_sense_regs SHALL hold the per-device sense bits.

Verification
REQ-027 Address 8'h05 selected -> a_select_out follows select_out; b_select_in returns via a_select_in; no operational_in.
REQ-028 Device 1 busy, ENABLE_SHORT_BUSY=0, READ -> initial status 8'h10, then disconnect.
REQ-029 READ, limit 6, channel takes 16 -> bytes 00..05, ending status 8'h0C, xfer_count 6.
REQ-030 WRITE, limit 16, channel stops after 6 -> last_write_data = 6th byte, ending status 8'h0C, xfer_count 6.
REQ-031 Command 8'hFF -> status 8'h0E; then SENSE -> byte 8'h80; a second SENSE -> 8'h00.
REQ-032 reset_n low during DATA -> all own in-tags low at once, state IDLE, xfer_count 0.

Source files
------------

// File: rtl/multi_device_cu_pkg.sv
// Bus-and-tag constants shared by the control unit: command codes, status bits, sense bits, FSM states.
// Pure definitions; no timing or flow control of its own.
package multi_device_cu_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_NOP   = 8'h03;
  localparam logic [7:0] CMD_SENSE = 8'h04;

  localparam logic [7:0] ST_SM   = 8'h40;
  localparam logic [7:0] ST_BUSY = 8'h10;
  localparam logic [7:0] ST_CE   = 8'h08;
  localparam logic [7:0] ST_DE   = 8'h04;
  localparam logic [7:0] ST_UC   = 8'h02;

  localparam int SENSE_CR_BIT  = 7;
  localparam int SENSE_BOC_BIT = 5;

  typedef enum logic [2:0] {
    IDLE, PROPAGATE, ADDR_IN, CMD_WAIT, INIT_STATUS, DATA, END_STATUS, DISCONNECT
  } cu_state_e;

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/multi_device_cu_if.sv
// One bus-and-tag channel segment; master drives the out-lines, slave drives the in-lines.
// Wires only: no latency, handshake is the interlocked tag protocol.
interface multi_device_cu_if;
  logic [7:0] bus_out;
  logic       bus_out_parity;
  logic       operational_out, hold_out, select_out, address_out;
  logic       command_out, service_out, suppress_out;
  logic [7:0] bus_in;
  logic       bus_in_parity;
  logic       operational_in, request_in, select_in, address_in;
  logic       status_in, service_in;

  modport master (
    output bus_out, bus_out_parity, operational_out, hold_out, select_out,
           address_out, command_out, service_out, suppress_out,
    input  bus_in, bus_in_parity, operational_in, request_in, select_in,
           address_in, status_in, service_in
  );
  modport slave (
    input  bus_out, bus_out_parity, operational_out, hold_out, select_out,
           address_out, command_out, service_out, suppress_out,
    output bus_in, bus_in_parity, operational_in, request_in, select_in,
           address_in, status_in, service_in
  );
endinterface

// File: rtl/multi_device_cu_sense.sv
// Per-device sense bits (command reject, bus-out check) with set/clear for the addressed device.
// Updates one cycle after the strobe; read port is combinational, no backpressure.
module cu_sense_regs
  import multi_device_cu_pkg::*;
#(
  parameter int NUM_DEVICES = 4,
  parameter int DEV_W       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DEV_W-1:0] dev_i,
  input  logic             set_cr_i,
  input  logic             set_boc_i,
  input  logic             clr_i,
  output logic [7:0]       sense_o
);
  logic [NUM_DEVICES-1:0] cr_q, cr_d, boc_q, boc_d;

  always_comb begin
    cr_d    = cr_q;
    boc_d   = boc_q;
    sense_o = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (dev_i == DEV_W'(i)) begin
        if (clr_i) begin
          cr_d[i]  = 1'b0;
          boc_d[i] = 1'b0;
        end
        if (set_cr_i)  cr_d[i]  = 1'b1;
        if (set_boc_i) boc_d[i] = 1'b1;
        sense_o[SENSE_CR_BIT]  = cr_q[i];
        sense_o[SENSE_BOC_BIT] = boc_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cr_q  <= '0;
      boc_q <= '0;
    end else begin
      cr_q  <= cr_d;
      boc_q <= boc_d;
    end
  end
endmodule

// File: rtl/multi_device_cu.sv
// Bus-and-tag control unit serving NUM_DEVICES addresses, passing other selections downstream.
// Own in-tags move one cycle after the sampled out-tag; each tag waits for the channel's response to fall.
module multi_device_cu
  import multi_device_cu_pkg::*;
#(
  parameter logic [7:0] BASE_ADDRESS      = 8'h10,
  parameter int         NUM_DEVICES       = 4,
  parameter int         LIMIT_WIDTH       = 16,
  parameter bit         ENABLE_SHORT_BUSY = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  multi_device_cu_if.slave                   b,
  multi_device_cu_if.master                  a,
  input  logic [NUM_DEVICES-1:0]             mock_busy,
  input  logic [NUM_DEVICES*LIMIT_WIDTH-1:0] mock_limit,
  output logic [7:0]                         last_write_data,
  output logic [LIMIT_WIDTH-1:0]             xfer_count
);
  localparam int DEV_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

  cu_state_e               state_q, state_d;
  logic [DEV_W-1:0]        dev_q, dev_d;
  logic [7:0]              cmd_q, cmd_d, status_q, status_d, bus_in_q, bus_in_d;
  logic [7:0]              lwd_q, lwd_d, sense_byte, own_bus;
  logic                    err_q, err_d, op_in_q, op_in_d, addr_in_q, addr_in_d;
  logic                    status_in_q, status_in_d, service_in_q, service_in_d;
  logic [LIMIT_WIDTH-1:0]  xfer_q, xfer_d, dev_limit, data_limit;
  logic [8:0]              off;
  logic [DEV_W-1:0]        sel_dev;
  logic                    in_range, sel_busy, dev_busy, par_err, resp_low, resp_any;
  logic                    set_cr, set_boc, clr_sense;

  assign off      = {1'b0, b.bus_out} - {1'b0, BASE_ADDRESS};
  assign in_range = !off[8] && (off < 9'(NUM_DEVICES));
  assign sel_dev  = off[DEV_W-1:0];
  assign par_err  = ~^{b.bus_out_parity, b.bus_out};
  assign resp_low = !b.service_out && !b.command_out;
  assign resp_any = b.service_out || b.command_out;

  always_comb begin
    sel_busy  = 1'b0;
    dev_busy  = 1'b0;
    dev_limit = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (sel_dev == DEV_W'(i)) sel_busy = mock_busy[i];
      if (dev_q == DEV_W'(i)) begin
        dev_busy  = mock_busy[i];
        dev_limit = mock_limit[i*LIMIT_WIDTH +: LIMIT_WIDTH];
      end
    end
  end

  // SENSE always moves exactly one byte regardless of the device limit.
  assign data_limit = (cmd_q == CMD_SENSE) ? LIMIT_WIDTH'(1) : dev_limit;

  always_comb begin
    state_d      = state_q;
    dev_d        = dev_q;
    cmd_d        = cmd_q;
    status_d     = status_q;
    err_d        = err_q;
    op_in_d      = op_in_q;
    addr_in_d    = addr_in_q;
    status_in_d  = status_in_q;
    service_in_d = service_in_q;
    bus_in_d     = bus_in_q;
    xfer_d       = xfer_q;
    lwd_d        = lwd_q;
    set_cr       = 1'b0;
    set_boc      = 1'b0;
    clr_sense    = 1'b0;
    case (state_q)
      IDLE: if (b.operational_out && b.select_out && b.address_out) begin
        if (in_range) begin
          dev_d   = sel_dev;
          op_in_d = 1'b1;
          xfer_d  = '0;
          err_d   = 1'b0;
          if (ENABLE_SHORT_BUSY && sel_busy) begin
            status_d = ST_SM | ST_BUSY;
            state_d  = INIT_STATUS;
          end else begin
            addr_in_d = 1'b1;
            bus_in_d  = b.bus_out;
            state_d   = ADDR_IN;
          end
        end else begin
          state_d = PROPAGATE;
        end
      end
      PROPAGATE: if (!b.select_out) state_d = IDLE;
      ADDR_IN:   if (!b.address_out) state_d = CMD_WAIT;
      CMD_WAIT: if (b.command_out) begin
        cmd_d     = b.bus_out;
        addr_in_d = 1'b0;
        state_d   = INIT_STATUS;
        if (dev_busy) begin
          status_d = ST_BUSY;
        end else if (par_err) begin
          status_d = ST_CE | ST_DE | ST_UC;
          set_boc  = 1'b1;
        end else begin
          case (b.bus_out)
            CMD_READ, CMD_WRITE, CMD_SENSE: status_d = 8'h00;
            CMD_NOP: status_d = ST_CE | ST_DE;
            default: begin
              status_d = ST_CE | ST_DE | ST_UC;
              set_cr   = 1'b1;
            end
          endcase
        end
      end
      INIT_STATUS, END_STATUS: begin
        if (!status_in_q) begin
          if (resp_low) begin
            status_in_d = 1'b1;
            if (state_q == END_STATUS) bus_in_d = err_q ? (ST_CE | ST_DE | ST_UC) : (ST_CE | ST_DE);
            else                       bus_in_d = status_q;
          end
        end else if (resp_any) begin
          status_in_d = 1'b0;
          bus_in_d    = '0;
          state_d     = (state_q == INIT_STATUS && status_q == 8'h00) ? DATA : DISCONNECT;
        end
      end
      DATA: begin
        if (!service_in_q) begin
          if (xfer_q == data_limit) begin
            state_d = END_STATUS;
          end else if (resp_low) begin
            service_in_d = 1'b1;
            bus_in_d = (cmd_q == CMD_READ)  ? 8'(xfer_q) :
                       (cmd_q == CMD_SENSE) ? sense_byte : 8'h00;
          end
        end else if (b.service_out) begin
          service_in_d = 1'b0;
          xfer_d       = xfer_q + 1'b1;
          if (cmd_q == CMD_WRITE) begin
            lwd_d = b.bus_out;
            if (par_err) begin
              set_boc = 1'b1;
              err_d   = 1'b1;
            end
          end
          if (cmd_q == CMD_SENSE) clr_sense = 1'b1;
        end else if (b.command_out) begin
          service_in_d = 1'b0;
          state_d      = END_STATUS;
        end
      end
      DISCONNECT: if (resp_low) begin
        op_in_d  = 1'b0;
        bus_in_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Losing operational_out aborts everything but the sense bits.
    if (state_q != IDLE && !b.operational_out) begin
      op_in_d      = 1'b0;
      addr_in_d    = 1'b0;
      status_in_d  = 1'b0;
      service_in_d = 1'b0;
      bus_in_d     = '0;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dev_q        <= '0;
      cmd_q        <= '0;
      status_q     <= '0;
      err_q        <= 1'b0;
      op_in_q      <= 1'b0;
      addr_in_q    <= 1'b0;
      status_in_q  <= 1'b0;
      service_in_q <= 1'b0;
      bus_in_q     <= '0;
      xfer_q       <= '0;
      lwd_q        <= '0;
    end else begin
      state_q      <= state_d;
      dev_q        <= dev_d;
      cmd_q        <= cmd_d;
      status_q     <= status_d;
      err_q        <= err_d;
      op_in_q      <= op_in_d;
      addr_in_q    <= addr_in_d;
      status_in_q  <= status_in_d;
      service_in_q <= service_in_d;
      bus_in_q     <= bus_in_d;
      xfer_q       <= xfer_d;
      lwd_q        <= lwd_d;
    end
  end

  cu_sense_regs #(.NUM_DEVICES(NUM_DEVICES), .DEV_W(DEV_W)) u_sense (
    .clk(clk), .reset_n(reset_n), .dev_i(dev_q), .set_cr_i(set_cr),
    .set_boc_i(set_boc), .clr_i(clr_sense), .sense_o(sense_byte)
  );

  assign a.bus_out         = b.bus_out;
  assign a.bus_out_parity  = b.bus_out_parity;
  assign a.operational_out = b.operational_out;
  assign a.hold_out        = b.hold_out;
  assign a.select_out      = (state_q == PROPAGATE) && b.select_out;
  assign a.address_out     = b.address_out;
  assign a.command_out     = b.command_out;
  assign a.service_out     = b.service_out;
  assign a.suppress_out    = b.suppress_out;

  // The downstream CU owns the channel whenever this one is not connected.
  assign own_bus          = op_in_q ? bus_in_q : a.bus_in;
  assign b.bus_in         = own_bus;
  assign b.bus_in_parity  = odd_par(own_bus);
  assign b.operational_in = op_in_q ? 1'b1         : a.operational_in;
  assign b.request_in     = op_in_q ? 1'b0         : a.request_in;
  assign b.select_in      = op_in_q ? 1'b0         : a.select_in;
  assign b.address_in     = op_in_q ? addr_in_q    : a.address_in;
  assign b.status_in      = op_in_q ? status_in_q  : a.status_in;
  assign b.service_in     = op_in_q ? service_in_q : a.service_in;

  assign last_write_data = lwd_q;
  assign xfer_count      = xfer_q;
endmodule

// File: tb/tb_multi_device_cu.sv
// Directed bench for multi_device_cu: channel-side protocol driver and a mock empty downstream segment.
module tb_multi_device_cu;
  import multi_device_cu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  mock_busy;
  logic [63:0] mock_limit;
  logic [7:0]  last_write_data;
  logic [15:0] xfer_count;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  rd_buf [0:31];
  logic [7:0]  last_echo;
  logic        last_echo_par;

  multi_device_cu_if b_if ();
  multi_device_cu_if a_if ();

  multi_device_cu dut (
    .clk(clk), .reset_n(reset_n), .b(b_if), .a(a_if),
    .mock_busy(mock_busy), .mock_limit(mock_limit),
    .last_write_data(last_write_data), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // Empty downstream: an unanswered selection loops straight back.
  assign a_if.select_in = a_if.select_out;

  function automatic logic tag(input int w);
    case (w)
      0: return b_if.operational_in;
      1: return b_if.address_in;
      2: return b_if.status_in;
      3: return b_if.service_in;
      default: return b_if.select_in;
    endcase
  endfunction

  task automatic wait_tag(input int w, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tag(w) === lvl) begin ok = 1'b1; break; end
    end
  endtask

  task automatic drive_bus(input logic [7:0] d, input logic bad);
    b_if.bus_out = d;
    b_if.bus_out_parity = bad ? ^d : ~^d;
  endtask

  task automatic accept_status(output bit ok);
    b_if.service_out = 1'b1;
    wait_tag(2, 1'b0, ok);
    b_if.service_out = 1'b0;
  endtask

  task automatic select_cmd(input logic [7:0] addr, input logic [7:0] cmd,
                            output logic [7:0] st, output bit ok);
    bit k;
    ok = 1'b1;
    drive_bus(addr, 1'b0);
    b_if.address_out = 1'b1;
    b_if.select_out  = 1'b1;
    wait_tag(1, 1'b1, k); ok &= k;
    last_echo = b_if.bus_in;
    last_echo_par = b_if.bus_in_parity;
    b_if.address_out = 1'b0;
    b_if.select_out  = 1'b0;
    @(negedge clk);
    drive_bus(cmd, 1'b0);
    b_if.command_out = 1'b1;
    wait_tag(1, 1'b0, k); ok &= k;
    b_if.command_out = 1'b0;
    wait_tag(2, 1'b1, k); ok &= k;
    st = b_if.bus_in;
    accept_status(k); ok &= k;
  endtask

  task automatic data_phase(input int stop_after, input int bad_idx, output int n,
                            output logic [7:0] end_st, output bit ok);
    bit k;
    n = 0; ok = 1'b0; end_st = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b_if.status_in === 1'b1) begin ok = 1'b1; break; end
      if (b_if.service_in === 1'b1) begin
        if (n == stop_after) begin
          b_if.command_out = 1'b1;
          wait_tag(3, 1'b0, k);
          b_if.command_out = 1'b0;
        end else begin
          rd_buf[n] = b_if.bus_in;
          drive_bus(8'hA0 + 8'(n), n == bad_idx);
          b_if.service_out = 1'b1;
          wait_tag(3, 1'b0, k);
          b_if.service_out = 1'b0;
          n++;
        end
      end
    end
    if (ok) begin end_st = b_if.bus_in; accept_status(k); ok = k; end
  endtask

  task automatic run_op(input logic [7:0] addr, input logic [7:0] cmd, input int stop_after,
                        input int bad_idx, output logic [7:0] init_st, output logic [7:0] end_st,
                        output int n, output bit ok);
    bit k;
    select_cmd(addr, cmd, init_st, ok);
    n = 0; end_st = 8'hFF;
    if (init_st === 8'h00) begin data_phase(stop_after, bad_idx, n, end_st, k); ok &= k; end
    wait_tag(0, 1'b0, k); ok &= k;
  endtask

  task automatic test_reset;
    b_if.bus_out = 8'h00; b_if.bus_out_parity = 1'b1;
    b_if.operational_out = 1'b1; b_if.hold_out = 1'b0; b_if.select_out = 1'b0;
    b_if.address_out = 1'b0; b_if.command_out = 1'b0; b_if.service_out = 1'b0;
    b_if.suppress_out = 1'b0;
    a_if.bus_in = 8'hA5; a_if.bus_in_parity = 1'b1; a_if.operational_in = 1'b0;
    a_if.request_in = 1'b0; a_if.address_in = 1'b0; a_if.status_in = 1'b0; a_if.service_in = 1'b0;
    mock_busy = 4'b0000;
    mock_limit = {16'd16, 16'd6, 16'd0, 16'd3};
    repeat (2) @(negedge clk);
    checks++; if (b_if.operational_in !== 1'b0) begin errors++; $display("FAIL rst_op_in: got %b want 0", b_if.operational_in); end
    checks++; if (xfer_count !== 16'd0) begin errors++; $display("FAIL rst_xfer: got %0d want 0", xfer_count); end
    checks++; if (last_write_data !== 8'h00) begin errors++; $display("FAIL rst_lwd: got %h want 00", last_write_data); end
    checks++; if (b_if.bus_in !== 8'hA5) begin errors++; $display("FAIL rst_bus_fwd: got %h want a5", b_if.bus_in); end
    checks++; if (b_if.bus_in_parity !== 1'b1) begin errors++; $display("FAIL rst_parity: got %b want 1", b_if.bus_in_parity); end
    checks++; if (a_if.select_out !== 1'b0) begin errors++; $display("FAIL rst_a_sel: got %b want 0", a_if.select_out); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_propagate;
    drive_bus(8'h05, 1'b0);
    b_if.address_out = 1'b1; b_if.select_out = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_if.select_out !== 1'b1) begin errors++; $display("FAIL prop_a_sel: got %b want 1", a_if.select_out); end
    checks++; if (b_if.select_in !== 1'b1) begin errors++; $display("FAIL prop_b_sel_in: got %b want 1", b_if.select_in); end
    checks++; if (b_if.operational_in !== 1'b0) begin errors++; $display("FAIL prop_op_in: got %b want 0", b_if.operational_in); end
    checks++; if (a_if.bus_out !== 8'h05) begin errors++; $display("FAIL prop_fwd_bus: got %h want 05", a_if.bus_out); end
    checks++; if (a_if.address_out !== 1'b1) begin errors++; $display("FAIL prop_fwd_addr: got %b want 1", a_if.address_out); end
    b_if.address_out = 1'b0; b_if.select_out = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (b_if.select_in !== 1'b0) begin errors++; $display("FAIL prop_release: got %b want 0", b_if.select_in); end
  endtask

  task automatic test_busy;
    logic [7:0] ist, est; int n; bit ok;
    mock_busy = 4'b0010;
    run_op(8'h11, CMD_READ, 16, -1, ist, est, n, ok);
    mock_busy = 4'b0000;
    checks++; if (!ok) begin errors++; $display("FAIL busy_handshake: ok=%0d want 1", ok); end
    checks++; if (ist !== 8'h10) begin errors++; $display("FAIL busy_status: got %h want 10", ist); end
    checks++; if (xfer_count !== 16'd0) begin errors++; $display("FAIL busy_xfer: got %0d want 0", xfer_count); end
  endtask

  task automatic test_read;
    logic [7:0] ist, est; int n; bit ok, bytes_ok;
    run_op(8'h12, CMD_READ, 16, -1, ist, est, n, ok);
    bytes_ok = 1'b1;
    for (int i = 0; i < 6; i++) if (rd_buf[i] !== 8'(i)) bytes_ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL read_handshake: ok=%0d want 1", ok); end
    checks++; if (last_echo !== 8'h12) begin errors++; $display("FAIL read_addr_echo: got %h want 12", last_echo); end
    checks++; if (last_echo_par !== 1'b1) begin errors++; $display("FAIL read_echo_par: got %b want 1", last_echo_par); end
    checks++; if (ist !== 8'h00) begin errors++; $display("FAIL read_init: got %h want 00", ist); end
    checks++; if (n !== 6) begin errors++; $display("FAIL read_count: got %0d want 6", n); end
    checks++; if (!bytes_ok) begin errors++; $display("FAIL read_bytes: got %h..%h want 00..05", rd_buf[0], rd_buf[5]); end
    checks++; if (est !== 8'h0C) begin errors++; $display("FAIL read_end: got %h want 0c", est); end
    checks++; if (xfer_count !== 16'd6) begin errors++; $display("FAIL read_xfer: got %0d want 6", xfer_count); end
  endtask

  task automatic test_write;
    logic [7:0] ist, est; int n; bit ok;
    run_op(8'h13, CMD_WRITE, 6, -1, ist, est, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_handshake: ok=%0d want 1", ok); end
    checks++; if (ist !== 8'h00) begin errors++; $display("FAIL write_init: got %h want 00", ist); end
    checks++; if (n !== 6) begin errors++; $display("FAIL write_count: got %0d want 6", n); end
    checks++; if (last_write_data !== 8'hA5) begin errors++; $display("FAIL write_lwd: got %h want a5", last_write_data); end
    checks++; if (est !== 8'h0C) begin errors++; $display("FAIL write_end: got %h want 0c", est); end
    checks++; if (xfer_count !== 16'd6) begin errors++; $display("FAIL write_xfer: got %0d want 6", xfer_count); end
  endtask

  task automatic test_limit_zero;
    logic [7:0] ist, est; int n; bit ok;
    run_op(8'h11, CMD_READ, 16, -1, ist, est, n, ok);
    checks++; if (n !== 0) begin errors++; $display("FAIL lim0_count: got %0d want 0", n); end
    checks++; if (est !== 8'h0C) begin errors++; $display("FAIL lim0_end: got %h want 0c", est); end
    checks++; if (xfer_count !== 16'd0) begin errors++; $display("FAIL lim0_xfer: got %0d want 0", xfer_count); end
  endtask

  task automatic test_reject_sense;
    logic [7:0] ist, est; int n; bit ok;
    run_op(8'h10, 8'hFF, 16, -1, ist, est, n, ok);
    checks++; if (ist !== 8'h0E) begin errors++; $display("FAIL rej_status: got %h want 0e", ist); end
    run_op(8'h10, CMD_SENSE, 16, -1, ist, est, n, ok);
    checks++; if (ist !== 8'h00) begin errors++; $display("FAIL sense1_init: got %h want 00", ist); end
    checks++; if (n !== 1) begin errors++; $display("FAIL sense1_count: got %0d want 1", n); end
    checks++; if (rd_buf[0] !== 8'h80) begin errors++; $display("FAIL sense1_byte: got %h want 80", rd_buf[0]); end
    checks++; if (est !== 8'h0C) begin errors++; $display("FAIL sense1_end: got %h want 0c", est); end
    run_op(8'h10, CMD_SENSE, 16, -1, ist, est, n, ok);
    checks++; if (rd_buf[0] !== 8'h00) begin errors++; $display("FAIL sense2_byte: got %h want 00", rd_buf[0]); end
  endtask

  task automatic test_write_parity;
    logic [7:0] ist, est; int n; bit ok;
    run_op(8'h13, CMD_WRITE, 4, 2, ist, est, n, ok);
    checks++; if (n !== 4) begin errors++; $display("FAIL par_count: got %0d want 4", n); end
    checks++; if (est !== 8'h0E) begin errors++; $display("FAIL par_end: got %h want 0e", est); end
    checks++; if (last_write_data !== 8'hA3) begin errors++; $display("FAIL par_lwd: got %h want a3", last_write_data); end
    run_op(8'h13, CMD_SENSE, 16, -1, ist, est, n, ok);
    checks++; if (rd_buf[0] !== 8'h20) begin errors++; $display("FAIL par_sense: got %h want 20", rd_buf[0]); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] ist; bit ok, k;
    select_cmd(8'h12, CMD_READ, ist, ok);
    wait_tag(3, 1'b1, k); ok &= k;
    b_if.service_out = 1'b1;
    wait_tag(3, 1'b0, k); ok &= k;
    b_if.service_out = 1'b0;
    wait_tag(3, 1'b1, k); ok &= k;
    checks++; if (!ok || xfer_count !== 16'd1) begin errors++; $display("FAIL mid_pre: ok=%0d xfer=%0d want 1/1", ok, xfer_count); end
    reset_n = 1'b0;
    #1;
    checks++; if (b_if.operational_in !== 1'b0) begin errors++; $display("FAIL mid_op_in: got %b want 0", b_if.operational_in); end
    checks++; if (b_if.service_in !== 1'b0) begin errors++; $display("FAIL mid_svc_in: got %b want 0", b_if.service_in); end
    checks++; if (b_if.bus_in !== 8'hA5) begin errors++; $display("FAIL mid_bus_fwd: got %h want a5", b_if.bus_in); end
    checks++; if (xfer_count !== 16'd0) begin errors++; $display("FAIL mid_xfer: got %0d want 0", xfer_count); end
    checks++; if (last_write_data !== 8'h00) begin errors++; $display("FAIL mid_lwd: got %h want 00", last_write_data); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL mid_state: got %0d want %0d", dut.state_q, IDLE); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_propagate();
    test_busy();
    test_read();
    test_write();
    test_limit_zero();
    test_reject_sense();
    test_write_parity();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
